// File: rtl/boot_loader_rx_if.sv
// Boot stream interface: the pin-side boot word stream plus the Icache write port.
// The boot master drives the stream; the boot receiver drives the Icache write port.
interface boot_loader_rx_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    // Stream semantics: there is no ready. A word is transferred on every rising clk edge
    // where boot_up is high, and ic_we is a one-cycle write strobe that is never back-pressured.
    logic                  boot_up;
    logic [ADDR_WIDTH-1:0] boot_addr;
    logic [DATA_WIDTH-1:0] boot_datai;
    logic                  ic_we;
    logic [ADDR_WIDTH-1:0] ic_addr;
    logic [DATA_WIDTH-1:0] ic_wdata;

    modport master (
        output boot_up, boot_addr, boot_datai,
        input  ic_we, ic_addr, ic_wdata
    );

    modport slave (
        input  boot_up, boot_addr, boot_datai,
        output ic_we, ic_addr, ic_wdata
    );
endinterface

// File: rtl/boot_loader_rx.sv
// Boot receiver: writes streamed boot words into the Icache, holds the pipeline for a flush
// window, then releases the core. Optional BOOT_CHECKSUM_EN adds a running word checksum.
module boot_loader_rx #(
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 32,
    parameter int FLUSH_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    boot_loader_rx_if.slave       bus,
    output logic                  core_run,
    output logic                  valid,
    output logic [ADDR_WIDTH:0]   words_loaded,
`ifdef BOOT_CHECKSUM_EN
    output logic [DATA_WIDTH-1:0] boot_csum,
`endif
    output logic [1:0]            state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        RUN   = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH:0] WORDS_MAX  = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [3:0]          FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

    state_t                state;
    logic [3:0]            flush_cnt;
    logic                  s1_up;
    logic [ADDR_WIDTH-1:0] s1_addr;
    logic [DATA_WIDTH-1:0] s1_data;
`ifndef BOOT_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] boot_csum;
`endif

    // S1 capture stage; the Icache write port is driven straight from it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_up   <= 1'b0;
            s1_addr <= '0;
            s1_data <= '0;
        end else begin
            s1_up   <= bus.boot_up;
            s1_addr <= bus.boot_addr;
            s1_data <= bus.boot_datai;
        end
    end

    assign bus.ic_we    = s1_up;
    assign bus.ic_addr  = s1_addr;
    assign bus.ic_wdata = s1_data;
    assign state_dbg    = state;

    // S1 only carries a word while in LOAD, so counting there sees every write. core_run
    // drops on the same edge that captures a new word, so it never overlaps ic_we.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            flush_cnt    <= '0;
            core_run     <= 1'b0;
            valid        <= 1'b0;
            words_loaded <= '0;
            boot_csum    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.boot_up) begin
                        state        <= LOAD;
                        words_loaded <= '0;
                        boot_csum    <= '0;
                    end
                end
                LOAD: begin
                    if (s1_up) begin
                        if (words_loaded != WORDS_MAX) words_loaded <= words_loaded + 1'b1;
                        boot_csum <= boot_csum + s1_data;
                    end else if (!bus.boot_up) begin
                        state     <= FLUSH;
                        flush_cnt <= FLUSH_INIT;
                    end
                end
                FLUSH: begin
                    if (bus.boot_up) begin
                        state <= LOAD;
                    end else if (flush_cnt == 4'd0) begin
                        state    <= RUN;
                        core_run <= 1'b1;
                        valid    <= 1'b1;
                    end else begin
                        flush_cnt <= flush_cnt - 1'b1;
                    end
                end
                RUN: begin
                    if (bus.boot_up) begin
                        state        <= LOAD;
                        core_run     <= 1'b0;
                        valid        <= 1'b0;
                        words_loaded <= '0;
                        boot_csum    <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
